// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers. Requesters are
// served one byte at a time in round-robin order. Each granted byte gets a
// one-cycle start pulse, and the arbiter waits for the transmitter's busy flag
// to clear before it grants again.
// Optional feature macro: UART_ARB_TAG_EN. When it is defined, a channel tag
// byte 8'hF0|grant_id goes out ahead of the data whenever the source changes.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT      = 3'd3
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG_ISSUE = 3'd4,
        S_TAG_WAIT  = 3'd5
`endif
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [7:0]         r_tx_data;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     r_last_grant;

`ifdef UART_ARB_TAG_EN
    logic [7:0]         r_hold;
    logic               r_tag_valid;
    logic [IDW-1:0]     r_tag_id;
    logic               w_tag_due;
    logic [7:0]         w_tag_byte;
`endif

    logic               w_any;
    logic [IDW-1:0]     w_winner;
    logic [NUM_REQ-1:0] w_winner_oh;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;

    // Round-robin search: first valid requester after the last one served
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_any && req_valid[j] &&
                    (j == ((int'(r_last_grant) + k) % NUM_REQ))) begin
                    w_any    = 1'b1;
                    w_winner = IDW'(j);
                end
            end
        end
    end

    // One-hot form of the winner, loaded into req_ready on the IDLE->GRANT edge
    always_comb begin
        w_winner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_winner_oh[i] = (w_winner == IDW'(i));
        end
    end

    // Valid bit and byte of the currently granted requester
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

`ifdef UART_ARB_TAG_EN
    // A tag is needed on the first grant after reset or when the source changes
    assign w_tag_due  = !r_tag_valid || (r_tag_id != r_grant_id);
    assign w_tag_byte = 8'hF0 | 8'(r_grant_id);
`endif

    // Sequencer: grant, capture the byte, start the transmitter, wait for the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= '0;
            r_tx_data    <= '0;
            r_grant_id   <= '0;
            r_last_grant <= IDW'(NUM_REQ - 1);
`ifdef UART_ARB_TAG_EN
            r_hold       <= '0;
            r_tag_valid  <= 1'b0;
            r_tag_id     <= '0;
`endif
        end else begin
            r_req_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_id  <= w_winner;
                        r_req_ready <= w_winner_oh;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A requester that dropped valid here withdrew; nothing moves
                    if (w_sel_valid) begin
                        r_last_grant <= r_grant_id;
`ifdef UART_ARB_TAG_EN
                        if (w_tag_due) begin
                            r_hold      <= w_sel_data;
                            r_tx_data   <= w_tag_byte;
                            r_tag_valid <= 1'b1;
                            r_tag_id    <= r_grant_id;
                            r_state     <= S_TAG_ISSUE;
                        end else begin
                            r_tx_data   <= w_sel_data;
                            r_state     <= S_ISSUE;
                        end
`else
                        r_tx_data <= w_sel_data;
                        r_state   <= S_ISSUE;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (!tx_busy) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef UART_ARB_TAG_EN
                S_TAG_ISSUE: begin
                    if (!tx_busy) begin
                        r_state <= S_TAG_WAIT;
                    end
                end
                S_TAG_WAIT: begin
                    if (!tx_busy) begin
                        r_tx_data <= r_hold;
                        r_state   <= S_ISSUE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Start is gated by busy directly, so a frame still running (for example
    // across a reset) can never be overlapped by a new start
`ifdef UART_ARB_TAG_EN
    assign tx_start = ((r_state == S_ISSUE) || (r_state == S_TAG_ISSUE)) && !tx_busy;
`else
    assign tx_start = (r_state == S_ISSUE) && !tx_busy;
`endif

    assign req_ready = r_req_ready;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;
    assign arb_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Randomized and directed stimulus for uart_tx_arbiter. A transaction-level
// model predicts the winner of each grant and the byte stream on the line.
// It follows the UART_ARB_TAG_EN macro in the same way as the design.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [IDW-1:0] grant_id;
    logic           arb_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // transmitter model state
    int   x_cnt = 0;
    int   x_len = 4;
    bit   rand_len = 1'b0;
    logic st_neg = 1'b0;
    int   cyc = 0;

    // arbiter model state
    int         m_last = N - 1;
    bit         m_tv = 1'b0;
    int         m_tid = 0;
    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];
    int         pend_w = -1;
    logic [N-1:0] rdy_cur = '0;
    logic [N-1:0] rdy_last = '0;
    bit         prev_start = 1'b0;
    bit         frame_chk = 1'b0;
    logic [7:0] frame_data = '0;
    bit         post_rst = 1'b0;
    int         post_start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // first requester with valid set, searching from last+1
    function automatic int rr(input int last, input logic [N-1:0] v);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // a grant observed last cycle turns into a transfer if valid was still held
    task automatic resolve();
        logic [7:0] b;
        if (pend_w >= 0 && !reset && req_valid[pend_w]) begin
`ifdef UART_ARB_TAG_EN
            if (!m_tv || m_tid != pend_w) begin
                exp_q.push_back(8'hF0 | 8'(pend_w));
                m_tv  = 1'b1;
                m_tid = pend_w;
            end
`endif
            b = req_data[8*pend_w +: 8];
            exp_q.push_back(b);
            m_last = pend_w;
        end
        pend_w = -1;
    endtask

    task automatic monitor();
        int w;
        st_neg   = tx_start;
        rdy_last = rdy_cur;
        rdy_cur  = req_ready;
        if (reset) begin
            m_last = N - 1;
            m_tv   = 1'b0;
            exp_q.delete();
            pend_w = -1;
            frame_chk  = 1'b0;
            prev_start = 1'b0;
            return;
        end
        if (tx_start) begin
            chk("start_while_busy", tx_busy, 0);
            chk("start_back_to_back", prev_start, 0);
            chk("arb_busy_on_start", arb_busy, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL start_unexpected actual=start data=%0h required=no start", tx_data);
            end else begin
                chk("tx_data", tx_data, exp_q.pop_front());
            end
            line_q.push_back(tx_data);
            frame_chk  = 1'b1;
            frame_data = tx_data;
            if (post_rst) begin
                post_start_cyc = cyc;
                post_rst = 1'b0;
            end
        end else if (tx_busy && frame_chk) begin
            chk("tx_data_hold", tx_data, frame_data);
        end
        prev_start = tx_start;
        if (req_ready != '0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            chk("ready_back_to_back", rdy_last, 0);
            chk("arb_busy_on_ready", arb_busy, 1);
            w = rr(m_last, req_valid);
            if (w < 0) begin
                checks++;
                errors++;
                $display("FAIL ready_without_valid actual=%0h required=0", req_ready);
            end else begin
                chk("ready_winner", req_ready, 1 << w);
                chk("grant_id", grant_id, w);
                pend_w = w;
            end
        end
    endtask

    // one clock: settle the pending grant, advance the transmitter, sample at negedge
    task automatic tick();
        resolve();
        @(posedge clk);
        #1;
        cyc++;
        if (st_neg) begin
            tx_busy = 1'b1;
            x_cnt = rand_len ? int'($urandom_range(1, 6)) : x_len;
        end else if (x_cnt > 0) begin
            x_cnt--;
            if (x_cnt == 0) tx_busy = 1'b0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || st_neg || pend_w >= 0) && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 1000, 1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic send(input int i, input logic [7:0] b);
        int n = 0;
        req_data[8*i +: 8] = b;
        req_valid[i] = 1'b1;
        do begin
            tick();
            n++;
        end while (!rdy_cur[i] && n < 200);
        chk("send_ready_timeout", rdy_cur[i], 1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic rand_drive();
        for (int i = 0; i < N; i++) begin
            if (rdy_cur[i] && req_valid[i] && $urandom_range(0, 7) == 0) begin
                req_valid[i] = 1'b0;
            end else if (rdy_last[i]) begin
                if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
                else req_data[8*i +: 8] = 8'($urandom);
            end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                req_data[8*i +: 8] = 8'($urandom);
                req_valid[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int n;
        int fall;
        logic [7:0] e;

        // reset values
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_arb_busy", arb_busy, 0);
        tick();
        reset = 1'b0;

        // single byte latency from requester 0
        req_data[7:0] = 8'h41;
        req_valid = 4'b0001;
        tick();
        chk("t1_ready_cycle1", req_ready, 4'b0001);
        tick();
        chk("t1_start_cycle2", tx_start, 1);
`ifdef UART_ARB_TAG_EN
        chk("t1_data_cycle2", tx_data, 8'hF0);
`else
        chk("t1_data_cycle2", tx_data, 8'h41);
`endif
        req_valid = '0;
`ifdef UART_ARB_TAG_EN
        for (int f = 0; f < 2; f++) begin
`else
        for (int f = 0; f < 1; f++) begin
`endif
            n = 0;
            do begin tick(); n++; end while (!tx_busy && n < 50);
            do begin tick(); n++; end while (tx_busy && n < 100);
            chk("t1_frame_timeout", n < 100, 1);
        end
        chk("t1_busy_at_fall", arb_busy, 1);
        tick();
        chk("t1_idle_after_fall", arb_busy, 0);
        drain();

        // all four held valid: strict rotation
        do_reset();
        line_q.delete();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        n = 0;
        while (line_q.size() < 10 && n < 2000) begin tick(); n++; end
        req_valid = '0;
        drain();
        chk("t2_count", line_q.size() >= 8, 1);
        for (int k = 0; k < 8 && k < line_q.size(); k++) begin
`ifdef UART_ARB_TAG_EN
            e = (k % 2 == 0) ? (8'hF0 | 8'((k / 2) % 4)) : (8'h10 + 8'((k / 2) % 4));
`else
            e = 8'h10 + 8'(k % 4);
`endif
            chk("t2_rotation", line_q[k], e);
        end

        // requester 2 withdraws during its grant; requester 3 is served next
        do_reset();
        req_data[23:16] = 8'h22;
        req_valid = 4'b0100;
        tick();
        chk("t3_ready2", req_ready, 4'b0100);
        req_data[31:24] = 8'h33;
        req_valid = 4'b1000;
        tick();
        chk("t3_no_start", tx_start, 0);
        tick();
        chk("t3_ready3", req_ready, 4'b1000);
        tick();
        chk("t3_start", tx_start, 1);
`ifdef UART_ARB_TAG_EN
        chk("t3_data", tx_data, 8'hF3);
`else
        chk("t3_data", tx_data, 8'h33);
`endif
        req_valid = '0;
        drain();

        // reset while the transmitter is mid-frame
        do_reset();
        x_len = 25;
        send(1, 8'h77);
        repeat (3) tick();
        chk("t4_busy_before_reset", tx_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_req_ready", req_ready, 0);
        chk("t4_async_tx_start", tx_start, 0);
        chk("t4_async_tx_data", tx_data, 0);
        chk("t4_async_grant_id", grant_id, 0);
        chk("t4_async_arb_busy", arb_busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        x_len = 4;
        post_rst = 1'b1;
        post_start_cyc = 0;
        send(0, 8'h5A);
        n = 0;
        while (tx_busy && n < 100) begin tick(); n++; end
        fall = cyc;
        chk("t4_first_start_at_fall", post_start_cyc, fall);
        drain();

        // repeated source then a new source
        do_reset();
        line_q.delete();
        send(1, 8'h55);
        send(1, 8'h55);
        send(3, 8'hAA);
        drain();
`ifdef UART_ARB_TAG_EN
        chk("t5_count", line_q.size(), 5);
        if (line_q.size() == 5) begin
            chk("t5_b0", line_q[0], 8'hF1);
            chk("t5_b1", line_q[1], 8'h55);
            chk("t5_b2", line_q[2], 8'h55);
            chk("t5_b3", line_q[3], 8'hF3);
            chk("t5_b4", line_q[4], 8'hAA);
        end
`else
        chk("t5_count", line_q.size(), 3);
        if (line_q.size() == 3) begin
            chk("t5_b0", line_q[0], 8'h55);
            chk("t5_b1", line_q[1], 8'h55);
            chk("t5_b2", line_q[2], 8'hAA);
        end
`endif

        // randomized traffic with random frame lengths
        do_reset();
        rand_len = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rand_drive();
        end
        req_valid = '0;
        drain();
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
